// File: rtl/udp_ts_pkg.sv
// Shared constants and write-FSM encoding for the UDP-to-TS receive path.
package udp_ts_pkg;
  localparam int         TS_LEN  = 188;
  localparam logic [7:0] TS_SYNC = 8'h47;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_WRITE   = 2'd1,
    WR_DISCARD = 2'd2,
    WR_RESYNC  = 2'd3
  } wr_state_t;
endpackage

// File: rtl/udp_ts_ptr_fifo.sv
// Show-ahead pointer FIFO; head/valid reflect the oldest entry without a read strobe.
module udp_ts_ptr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [AW:0]      count;
  logic             do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign head   = valid ? mem[rd_idx] : '0;

  always_ff @(posedge clk)
    if (push) mem[wr_idx] <= push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_idx <= (wr_idx == AW'(DEPTH-1)) ? '0 : wr_idx + 1'b1;
      if (do_pop) rd_idx <= (rd_idx == AW'(DEPTH-1)) ? '0 : rd_idx + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  // Depth equals the slot count, so a push into a full queue means a pointer was duplicated.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !do_pop && count == (AW+1)'(DEPTH)));
`endif
endmodule

// File: rtl/udp_ts_rx_buf_writer.sv
// Splits UDP payloads into 188-byte TS packets, writes them into frame-buffer slots
// fetched from the buffer control, and queues completed slot pointers for the reader.
module udp_ts_rx_buf_writer
  import udp_ts_pkg::*;
#(
  parameter int P_POINTERS      = 16,
  parameter int P_POINTER_WIDTH = 4,
  parameter int P_OFFSET_WIDTH  = 8
) (
  input  logic                                    payload_clk,
  input  logic                                    payload_rst,
  input  logic [7:0]                              udp_data,
  input  logic                                    udp_valid,
  input  logic                                    udp_sop,
  input  logic                                    udp_eop,
  input  logic                                    buf_low,
  output logic                                    rx_free_fetch,
  input  logic                                    rx_free_fetch_ack,
  input  logic [P_POINTER_WIDTH-1:0]              pointer_in,
  output logic                                    buf_wr_en,
  output logic [P_POINTER_WIDTH+P_OFFSET_WIDTH-1:0] buf_wr_addr,
  output logic [7:0]                              buf_wr_data,
  output logic                                    ts_ready_valid,
  output logic [P_POINTER_WIDTH-1:0]              ts_ready_pointer,
  input  logic                                    ts_ready_ack,
  output logic [15:0]                             drop_count
);
  localparam int PW = P_POINTER_WIDTH;
  localparam int OW = P_OFFSET_WIDTH;

  wr_state_t       state, state_d;
  logic [PW-1:0]   spare, cur, push_ptr;
  logic            spare_valid, cur_valid, in_dgram, push_q;
  logic [OW-1:0]   cnt, eff_cnt;
  logic            acc, last, ts_start;
  logic            wr_go, take_spare, push;
  logic [1:0]      drop_add;
  logic [16:0]     drop_sum;

  assign acc      = udp_valid && (udp_sop || in_dgram);
  assign eff_cnt  = udp_sop ? '0 : cnt;
  assign last     = (eff_cnt == OW'(TS_LEN-1));
  assign ts_start = udp_sop || (state == WR_IDLE && eff_cnt == '0);
  assign drop_sum = {1'b0, drop_count} + 17'(drop_add);

  always_comb begin
    state_d    = state;
    wr_go      = 1'b0;
    take_spare = 1'b0;
    push       = 1'b0;
    drop_add   = 2'd0;
    if (acc) begin
      if (ts_start) begin
        // A sop while a packet is half written abandons it; the slot stays in cur.
        if (udp_sop && state == WR_WRITE) drop_add = 2'd1;
        if (udp_data == TS_SYNC && (cur_valid || spare_valid)) begin
          wr_go      = 1'b1;
          take_spare = !cur_valid;
          state_d    = WR_WRITE;
        end else begin
          drop_add = 2'(drop_add + 2'd1);
          state_d  = (udp_data == TS_SYNC) ? WR_DISCARD : WR_RESYNC;
        end
      end else begin
        case (state)
          WR_WRITE: begin
            wr_go = 1'b1;
            if (last) begin
              push    = 1'b1;
              state_d = WR_IDLE;
            end
          end
          WR_DISCARD: if (last) state_d = WR_IDLE;
          default: ;
        endcase
      end
      if (udp_eop && state_d != WR_IDLE) begin
        if (state_d == WR_WRITE) drop_add = 2'(drop_add + 2'd1);
        state_d = WR_IDLE;
      end
    end
  end

  always_ff @(posedge payload_clk or posedge payload_rst) begin
    if (payload_rst) begin
      state         <= WR_IDLE;
      cnt           <= '0;
      in_dgram      <= 1'b0;
      rx_free_fetch <= 1'b0;
      spare         <= '0;
      spare_valid   <= 1'b0;
      cur           <= '0;
      cur_valid     <= 1'b0;
      buf_wr_en     <= 1'b0;
      buf_wr_addr   <= '0;
      buf_wr_data   <= '0;
      push_q        <= 1'b0;
      push_ptr      <= '0;
      drop_count    <= '0;
    end else begin
      state <= state_d;
      if (acc) begin
        cnt      <= last ? '0 : eff_cnt + 1'b1;
        in_dgram <= !udp_eop;
      end
      // Spare is only empty while a fetch is outstanding, so ack and take_spare never coincide.
      if (rx_free_fetch && rx_free_fetch_ack) begin
        rx_free_fetch <= 1'b0;
        spare         <= pointer_in;
        spare_valid   <= 1'b1;
      end else if (!rx_free_fetch && !spare_valid && !buf_low) begin
        rx_free_fetch <= 1'b1;
      end
      if (take_spare) begin
        spare_valid <= 1'b0;
        cur         <= spare;
        cur_valid   <= 1'b1;
      end
      if (push) cur_valid <= 1'b0;
      buf_wr_en <= wr_go;
      if (wr_go) begin
        buf_wr_addr <= {(take_spare ? spare : cur), eff_cnt};
        buf_wr_data <= udp_data;
      end
      // Queue push lags one cycle so the last byte write lands before the reader sees the slot.
      push_q   <= push;
      push_ptr <= cur;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  udp_ts_ptr_fifo #(.DEPTH(P_POINTERS), .WIDTH(PW)) u_ready_q (
    .clk       (payload_clk),
    .rst       (payload_rst),
    .push      (push_q),
    .push_data (push_ptr),
    .pop       (ts_ready_ack),
    .valid     (ts_ready_valid),
    .head      (ts_ready_pointer)
  );
endmodule

// File: tb/tb_udp_ts_rx_buf_writer.sv
// Scoreboard bench: expected writes/pointers queued at stimulus time, checked as the DUT emits them.
module tb_udp_ts_rx_buf_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  udp_data;
  logic        udp_valid, udp_sop, udp_eop, buf_low;
  logic        rx_free_fetch, rx_free_fetch_ack;
  logic [3:0]  pointer_in;
  logic        buf_wr_en;
  logic [11:0] buf_wr_addr;
  logic [7:0]  buf_wr_data;
  logic        ts_ready_valid;
  logic [3:0]  ts_ready_pointer;
  logic        ts_ready_ack;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  udp_ts_rx_buf_writer dut (
    .payload_clk(clk), .payload_rst(rst),
    .udp_data(udp_data), .udp_valid(udp_valid), .udp_sop(udp_sop), .udp_eop(udp_eop),
    .buf_low(buf_low), .rx_free_fetch(rx_free_fetch), .rx_free_fetch_ack(rx_free_fetch_ack),
    .pointer_in(pointer_in), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
    .buf_wr_data(buf_wr_data), .ts_ready_valid(ts_ready_valid),
    .ts_ready_pointer(ts_ready_pointer), .ts_ready_ack(ts_ready_ack), .drop_count(drop_count)
  );

  int errs = 0, checks = 0;
  logic [19:0] exp_wr[$];
  logic [3:0]  exp_rdy[$];
  logic [3:0]  given[$];
  int          exp_drop = 0;
  logic [3:0]  held;
  bit          held_valid = 0;
  bit          fetch_seen = 0;
  bit          gap_mode = 0, prev_wr = 0;
  int          falls = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Buffer-control stand-in: acks each fetch after a short latency, pointers handed out round-robin.
  initial begin
    int lat = 0;
    logic [3:0] next_free = 4'd3;
    rx_free_fetch_ack = 1'b0;
    pointer_in = '0;
    forever begin
      @(negedge clk);
      rx_free_fetch_ack = 1'b0;
      if (rx_free_fetch && !rst) begin
        if (lat == 2) begin
          rx_free_fetch_ack = 1'b1;
          pointer_in = next_free;
          given.push_back(next_free);
          next_free++;
          lat = 0;
        end else lat++;
      end else lat = 0;
    end
  end

  always @(negedge clk) begin
    if (rx_free_fetch) fetch_seen = 1;
    if (gap_mode && prev_wr && !buf_wr_en) falls++;
    prev_wr = buf_wr_en;
    if (buf_wr_en) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", {buf_wr_addr, buf_wr_data}, 0);
      else chk("wr", {buf_wr_addr, buf_wr_data}, exp_wr.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    @(negedge clk);
    udp_valid = 1'b1; udp_data = d; udp_sop = sop; udp_eop = eop;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    udp_valid = 1'b0; udp_sop = 1'b0; udp_eop = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // bad_ts: index of the TS whose first byte is corrupted (-1 for none).
  task automatic send_dgram(input int len, input int bad_ts);
    logic [3:0] p = '0;
    bit writing = 0, lost = 0;
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      int off = i % 188;
      int ts  = i / 188;
      if (off == 0 && !lost) begin
        writing = 0;
        if (ts == bad_ts) begin lost = 1; exp_drop++; end
        else if (held_valid) begin p = held; writing = 1; end
        else if (given.size() > 0) begin p = given.pop_front(); held = p; held_valid = 1; writing = 1; end
        else exp_drop++;
      end
      if (lost) writing = 0;
      d = (off == 0) ? ((ts == bad_ts) ? 8'h00 : 8'h47) : 8'($urandom_range(0, 255));
      if (writing) exp_wr.push_back({p, 8'(off), d});
      if (writing && off == 187) begin exp_rdy.push_back(p); held_valid = 0; writing = 0; end
      send_byte(d, i == 0, i == len - 1);
    end
    if (writing) exp_drop++;
  endtask

  task automatic drain();
    while (exp_rdy.size() > 0) begin
      int t = 0;
      while (!ts_ready_valid && t < 50) begin @(negedge clk); t++; end
      chk("rdy_valid", ts_ready_valid, 1);
      chk("rdy_ptr", ts_ready_pointer, exp_rdy.pop_front());
      ts_ready_ack = 1'b1;
      @(negedge clk);
      ts_ready_ack = 1'b0;
    end
    @(negedge clk);
    chk("rdy_empty", ts_ready_valid, 0);
    chk("wr_left", exp_wr.size(), 0);
    chk("drop", drop_count, exp_drop);
  endtask

  initial begin
    rst = 1'b1; udp_data = '0; udp_valid = 0; udp_sop = 0; udp_eop = 0;
    buf_low = 0; ts_ready_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_addr", buf_wr_addr, 0);
    chk("rst_data", buf_wr_data, 0);
    chk("rst_fetch", rx_free_fetch, 0);
    chk("rst_rdy_valid", ts_ready_valid, 0);
    chk("rst_rdy_ptr", ts_ready_pointer, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    idle(10);

    // 1: single TS
    send_dgram(188, -1); idle(5); drain();
    // 2: 7 TS back-to-back, writes must be gap-free
    falls = 0; prev_wr = 0; gap_mode = 1;
    send_dgram(1316, -1); idle(5);
    gap_mode = 0;
    chk("t2_gaps", falls, 1);
    chk("t2_queued", exp_rdy.size(), 7);
    drain();
    // 3: second TS loses sync
    send_dgram(376, 1); idle(5); drain();
    // 4: short datagram, then full one reusing the held slot
    send_dgram(100, -1); idle(5);
    chk("t4_drop", drop_count, exp_drop);
    send_dgram(188, -1); idle(5); drain();
    // 5: buf_low with nothing held
    @(negedge clk); buf_low = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    given.delete(); held_valid = 0; exp_drop = 0;
    chk("t5_rst_drop", drop_count, 0);
    fetch_seen = 0;
    idle(5);
    send_dgram(188, -1); idle(5);
    chk("t5_drop", drop_count, 1);
    chk("t5_no_fetch", fetch_seen, 0);
    drain();
    buf_low = 1'b0;
    idle(12);
    // 6: pop coincides with push while one entry is queued
    send_dgram(188, -1); idle(20);
    chk("t6_one_entry", ts_ready_valid, 1);
    send_dgram(188, -1);
    @(negedge clk);
    udp_valid = 1'b0; udp_sop = 1'b0; udp_eop = 1'b0;
    chk("t6_head0", ts_ready_pointer, exp_rdy.pop_front());
    ts_ready_ack = 1'b1;
    @(negedge clk);
    ts_ready_ack = 1'b0;
    chk("t6_valid_kept", ts_ready_valid, 1);
    chk("t6_head1", ts_ready_pointer, exp_rdy[0]);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d checks expected completion", checks);
    $fatal(1);
  end
endmodule
